// File: rtl/operand_fetch.sv
// Operand fetch sequencer: reads 0-2 operand bytes at the program counter and
// strobes each byte out to the downstream address latch.
module operand_fetch #(
   parameter logic [15:0] RESET_PC = 16'hFFFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  len,
   input  logic        pc_load,
   input  logic [15:0] pc_in,
   output logic [15:0] pc,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_data,
   output logic [7:0]  op_data,
   output logic        latch_l,
   output logic        latch_h,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH_L = 2'd1,
      FETCH_H = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t state;
   logic   two_bytes;

   // The read address is the registered PC itself, so it cannot move before the ack.
   assign mem_addr = pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         mem_rd    <= 1'b0;
         op_data   <= 8'h00;
         latch_l   <= 1'b0;
         latch_h   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         two_bytes <= 1'b0;
      end else begin
         latch_l <= 1'b0;
         latch_h <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (pc_load) begin
                  pc <= pc_in;
               end else if (start) begin
                  busy <= 1'b1;
                  if (len == 2'd0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state     <= FETCH_L;
                     mem_rd    <= 1'b1;
                     // len 2 and 3 both mean two bytes
                     two_bytes <= len[1];
                  end
               end
            end
            FETCH_L: begin
               if (mem_ack) begin
                  op_data <= mem_data;
                  latch_l <= 1'b1;
                  pc      <= pc + 16'd1;
                  if (two_bytes) begin
                     state <= FETCH_H;
                  end else begin
                     state  <= DONE;
                     mem_rd <= 1'b0;
                     done   <= 1'b1;
                  end
               end
            end
            FETCH_H: begin
               if (mem_ack) begin
                  op_data <= mem_data;
                  latch_h <= 1'b1;
                  pc      <= pc + 16'd1;
                  state   <= DONE;
                  mem_rd  <= 1'b0;
                  done    <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               mem_rd <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'hFFFC, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request an operand fetch sequence; sampled only in IDLE.
REQ-005 SHALL have port: len  input  2  operand byte count sampled with start: 0, 1 or 2; value 3 is treated as 2.
REQ-006 SHALL have port: pc_load  input  1  load PC from pc_in; sampled only in IDLE.
REQ-007 SHALL have port: pc_in  input  16  new PC value.
REQ-008 SHALL have port: pc  output  16  current program counter.
REQ-009 SHALL have port: mem_rd  output  1  memory read request.
REQ-010 SHALL have port: mem_addr  output  16  read address, equal to pc while mem_rd=1.
REQ-011 SHALL have port: mem_ack  input  1  read completes in any cycle where mem_rd=1 and mem_ack=1.
REQ-012 SHALL have port: mem_data  input  8  read data, valid in the mem_ack cycle.
REQ-013 SHALL have port: op_data  output  8  operand byte for the downstream address latch.
REQ-014 SHALL have port: latch_l  output  1  one-cycle strobe: op_data is the low operand byte.
REQ-015 SHALL have port: latch_h  output  1  one-cycle strobe: op_data is the high operand byte.
REQ-016 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port: done  output  1  one-cycle pulse that ends a sequence.

Function
REQ-018 SHALL implement the states IDLE, FETCH_L, FETCH_H and DONE, with all outputs registered.
REQ-019 SHALL move from IDLE to DONE when start=1 and len=0, and SHALL issue no memory read in that case.
REQ-020 SHALL move from IDLE to FETCH_L when start=1 and len>=1, and SHALL latch the effective len.
REQ-021 SHALL hold mem_rd=1 in FETCH_L and FETCH_H, keeping mem_addr stable until mem_ack.
REQ-022 SHALL, on the ack in FETCH_L, register op_data<=mem_data, pulse latch_l next cycle and set pc<=pc+1.
REQ-023 SHALL, from FETCH_L, go to FETCH_H on ack if len=2, and to DONE on ack otherwise.
REQ-024 SHALL, on the ack in FETCH_H, register op_data<=mem_data, pulse latch_h next cycle, set pc<=pc+1 and go to DONE.
REQ-025 SHALL assert done for exactly the one cycle spent in DONE, coincident with the final strobe, then return to IDLE.
REQ-026 SHALL deassert mem_rd in the cycle after the ack.
REQ-027 SHALL keep op_data stable until the next ack.
REQ-028 SHALL never assert latch_l and latch_h in the same cycle.
REQ-029 SHALL wrap pc modulo 2^16 (16'hFFFF+1 = 16'h0000).
REQ-030 SHALL ignore start and pc_load while busy=1.
REQ-031 SHALL apply pc_load and ignore start when both are asserted in IDLE; pc=pc_in in the next cycle.
REQ-032 SHALL give latency, with mem_ack tied high, from start to done of: 1 cycle for len=0, 2 cycles for len=1, 3 cycles for len=2.

Reset
REQ-033 SHALL, on reset asserted at any time (including mid-fetch), immediately go to IDLE with pc=RESET_PC, mem_rd=0, mem_addr=RESET_PC, op_data=8'h00, and latch_l, latch_h, busy and done all 0.
REQ-034 SHALL begin normal operation on the first rising clk edge after reset deasserts.

Verification
REQ-035 SHALL cover: reset, then pc_load with pc_in=16'h8000, then start with len=2, mem_ack=1 and data 34,12 -> reads at 8000 then 8001; latch_l with op_data=34 at cycle+2; latch_h with op_data=12 and done at cycle+3; pc=8002.
REQ-036 SHALL cover: start with len=0 -> done one cycle later, mem_rd never high, pc unchanged.
REQ-037 SHALL cover: len=1 with mem_ack delayed 3 cycles, pc=16'hFFFF -> mem_addr=FFFF held for 4 cycles; latch_l and done follow; pc=0000.
REQ-038 SHALL cover: start and pc_load pulsed while busy -> both ignored, sequence unchanged.
REQ-039 SHALL cover: reset asserted during FETCH_H wait -> same cycle mem_rd=0, busy=0, pc=FFFC; no strobes after.
REQ-040 SHALL cover: len=3 -> two bytes fetched, identical to len=2.
